alu_share_arbiter: RTL and testbench

Shares one ALU instance between two requesters: slot 0 is the execute stage and slot 1 is the branch/address-compare path. It performs round-robin arbitration, latches the winner's operands, and drives the ALU from registers. It then captures Result/Zero/Less into a response register, which it holds until the owning requester takes it. The block sits between the decode/issue logic and the ALU; the ALU is instantiated beside it, not inside it.

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu_share_arbiter_rr.sv | 26 ++
 rtl/alu_share_arbiter.sv | 136 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_pkg : op encodings, packed-op field offsets and arbiter FSM states
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
package alu_pkg;

  localparam int OPW = 17;

  // Packed op layout, MSB first: {aluop[1:0], funct3[2:0], funct7[6:0], shamt[4:0]}
  localparam int OP_SHAMT_LSB  = 0;
  localparam int OP_SHAMT_W    = 5;
  localparam int OP_FUNCT7_LSB = 5;
  localparam int OP_FUNCT7_W   = 7;
  localparam int OP_FUNCT3_LSB = 12;
  localparam int OP_FUNCT3_W   = 3;
  localparam int OP_ALUOP_LSB  = 15;
  localparam int OP_ALUOP_W    = 2;

  localparam logic [1:0] ALUOP_ARITH = 2'b00;
  localparam logic [1:0] ALUOP_SHIFT = 2'b01;
  localparam logic [1:0] ALUOP_CMP   = 2'b10;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_share_arbiter_rr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arbiter2 : combinational two-way round-robin grant
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
module rr_arbiter2
  import alu_pkg::*;
(
  input  logic [1:0] req_valid_i,
  input  logic       last_grant_i,
  output logic       grant_valid_o,
  output logic       grant_o
);

  assign grant_valid_o = |req_valid_i;

  always_comb begin
    grant_o = req_valid_i[1];
    // Under contention the slot that did not win last time goes first.
    if (&req_valid_i) begin
      grant_o = ~last_grant_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_share_arbiter : shares one external ALU between execute and branch slots
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OPW  = alu_pkg::OPW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [2*XLEN-1:0] req_a,
  input  logic [2*XLEN-1:0] req_b,
  input  logic [2*OPW-1:0]  req_op,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [XLEN-1:0]   rsp_result,
  output logic              rsp_zero,
  output logic              rsp_less,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [1:0]        alu_aluop,
  output logic [2:0]        alu_funct3,
  output logic [6:0]        alu_funct7,
  output logic [4:0]        alu_shamt,
  input  logic [XLEN-1:0]   alu_result,
  input  logic              alu_zero,
  input  logic              alu_less,
  output logic              busy
);

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              owner_q, owner_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [OPW-1:0]    op_q, op_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              zero_q, zero_d;
  logic              less_q, less_d;
  logic              grant_valid;
  logic              grant;

  rr_arbiter2 u_rr (
    .req_valid_i   (req_valid),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (grant_valid),
    .grant_o       (grant)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    result_d     = result_q;
    zero_d       = zero_q;
    less_d       = less_q;
    req_ready    = 2'b00;
    rsp_valid    = 2'b00;

    case (state_q)
      ST_IDLE: begin
        // Ready is only raised toward a valid slot, so a grant is a handshake.
        if (grant_valid) begin
          req_ready[grant] = 1'b1;
          a_d          = grant ? req_a[2*XLEN-1:XLEN] : req_a[XLEN-1:0];
          b_d          = grant ? req_b[2*XLEN-1:XLEN] : req_b[XLEN-1:0];
          op_d         = grant ? req_op[2*OPW-1:OPW]  : req_op[OPW-1:0];
          owner_d      = grant;
          last_grant_d = grant;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        result_d = alu_result;
        zero_d   = alu_zero;
        less_d   = alu_less;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid[owner_q] = 1'b1;
        if (rsp_ready[owner_q]) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      less_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      less_q       <= less_d;
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_aluop  = op_q[OP_ALUOP_LSB  +: OP_ALUOP_W];
  assign alu_funct3 = op_q[OP_FUNCT3_LSB +: OP_FUNCT3_W];
  assign alu_funct7 = op_q[OP_FUNCT7_LSB +: OP_FUNCT7_W];
  assign alu_shamt  = op_q[OP_SHAMT_LSB  +: OP_SHAMT_W];

  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign rsp_less   = less_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_alu_share_arbiter : scoreboard bench with a behavioural ALU beside the DUT
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int XLEN = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [2*XLEN-1:0] req_a, req_b;
  logic [2*OPW-1:0]  req_op;
  logic [XLEN-1:0]   rsp_result, alu_a, alu_b, alu_result;
  logic              rsp_zero, rsp_less, alu_zero, alu_less, busy;
  logic [1:0]        alu_aluop;
  logic [2:0]        alu_funct3;
  logic [6:0]        alu_funct7;
  logic [4:0]        alu_shamt;

  always #5 clk = ~clk;

  alu_share_arbiter #(.XLEN(XLEN), .OPW(OPW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_less(rsp_less),
    .alu_a(alu_a), .alu_b(alu_b), .alu_aluop(alu_aluop),
    .alu_funct3(alu_funct3), .alu_funct7(alu_funct7), .alu_shamt(alu_shamt),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_less(alu_less),
    .busy(busy)
  );

  // Returns {less, zero, result}; Less is a signed compare for every op.
  function automatic logic [XLEN+1:0] alu_f(input logic [1:0] op, input logic [2:0] f3,
                                            input logic [6:0] f7, input logic [4:0] sh,
                                            input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    logic            alt;
    r   = '0;
    alt = (f7 == FUNCT7_ALT);
    case (op)
      ALUOP_ARITH: case (f3)
        F3_ADD:  r = alt ? a - b : a + b;
        F3_XOR:  r = a ^ b;
        F3_OR:   r = a | b;
        F3_AND:  r = a & b;
        default: r = '0;
      endcase
      ALUOP_SHIFT: case (f3)
        F3_SLL:  r = a << sh;
        F3_SR:   r = alt ? $unsigned($signed(a) >>> sh) : a >> sh;
        default: r = '0;
      endcase
      ALUOP_CMP: case (f3)
        F3_SLT:  r = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
        F3_SLTU: r = {{(XLEN-1){1'b0}}, a < b};
        default: r = '0;
      endcase
      default: r = '0;
    endcase
    return {($signed(a) < $signed(b)), (r == '0), r};
  endfunction

  assign {alu_less, alu_zero, alu_result} =
    alu_f(alu_aluop, alu_funct3, alu_funct7, alu_shamt, alu_a, alu_b);

  function automatic logic [OPW-1:0] mk_op(input logic [1:0] op, input logic [2:0] f3,
                                           input logic [6:0] f7, input logic [4:0] sh);
    return {op, f3, f7, sh};
  endfunction

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic            slot;
    logic [XLEN-1:0] res;
    logic            z;
    logic            l;
  } exp_t;

  exp_t sb_q[$];

  logic [XLEN-1:0] pa [2];
  logic [XLEN-1:0] pb [2];
  logic [OPW-1:0]  pop[2];
  logic [XLEN-1:0] er [2];
  logic            ez [2];
  logic            el [2];
  logic            exp_last;

  // Response scoreboard: compare at every completed response handshake.
  always @(negedge clk) begin
    if ((rsp_valid & rsp_ready) != 2'b00) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_rsp", 32'(rsp_valid), 32'(0));
      end else begin
        check("sb_slot",   32'(rsp_valid), 32'(1) << sb_q[0].slot);
        check("sb_result", rsp_result,     sb_q[0].res);
        check("sb_zero",   32'(rsp_zero),  32'(sb_q[0].z));
        check("sb_less",   32'(rsp_less),  32'(sb_q[0].l));
        void'(sb_q.pop_front());
      end
    end
  end

  task automatic drive_payload();
    req_a  = {pa[1], pa[0]};
    req_b  = {pb[1], pb[0]};
    req_op = {pop[1], pop[0]};
  endtask

  task automatic load(input int s, input logic [31:0] a, input logic [31:0] b,
                      input logic [OPW-1:0] op, input logic [31:0] r, input logic z, input logic l);
    pa[s] = a; pb[s] = b; pop[s] = op;
    er[s] = r; ez[s] = z; el[s] = l;
    req_valid[s] = 1'b1;
    drive_payload();
  endtask

  task automatic load_model(input int s);
    logic [31:0]     a, b;
    logic [OPW-1:0]  op;
    logic [XLEN+1:0] m;
    a = $urandom;
    b = $urandom;
    case ($urandom_range(0, 3))
      0:       op = mk_op(ALUOP_ARITH, F3_ADD, 7'd0, 5'd0);
      1:       op = mk_op(ALUOP_ARITH, F3_ADD, FUNCT7_ALT, 5'd0);
      2:       op = mk_op(ALUOP_ARITH, F3_XOR, 7'd0, 5'd0);
      default: op = mk_op(ALUOP_CMP, F3_SLTU, 7'd0, 5'd0);
    endcase
    m = alu_f(op[16:15], op[14:12], op[11:5], op[4:0], a, b);
    load(s, a, b, op, m[XLEN-1:0], m[XLEN], m[XLEN+1]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_last = 1'b1;
  endtask

  // Waits for the grant, checks it against the round-robin model, leaves the DUT in EXEC.
  task automatic accept(output int w);
    int   n;
    exp_t e;
    n = 0;
    w = (req_valid == 2'b11) ? int'(!exp_last) : (req_valid[1] ? 1 : 0);
    #1;
    while (req_ready == 2'b00 && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    check("req_ready", 32'(req_ready), 32'(1) << w);
    @(posedge clk); #1;
    req_valid[w] = 1'b0;
    exp_last     = w[0];
    e.slot = w[0]; e.res = er[w]; e.z = ez[w]; e.l = el[w];
    check("exec_busy",      32'(busy),      32'(1));
    check("exec_rsp_valid", 32'(rsp_valid), 32'(0));
    check("exec_alu_a",     alu_a,          pa[w]);
    check("exec_alu_b",     alu_b,          pb[w]);
    check("exec_alu_op",    32'({alu_aluop, alu_funct3, alu_funct7, alu_shamt}), 32'(pop[w]));
    sb_q.push_back(e);
  endtask

  task automatic run_one(input int hold, output int w);
    accept(w);
    @(posedge clk); #1;
    check("rsp_valid_latency", 32'(rsp_valid), 32'(1) << w);
    check("rsp_result",        rsp_result,     er[w]);
    for (int i = 0; i < hold; i++) begin
      rsp_ready = 2'b01 << (1 - w);
      @(posedge clk); #1;
      check("hold_rsp_valid", 32'(rsp_valid), 32'(1) << w);
      check("hold_busy",      32'(busy),      32'(1));
      check("hold_result",    rsp_result,     er[w]);
      check("hold_zero",      32'(rsp_zero),  32'(ez[w]));
    end
    rsp_ready = 2'b01 << w;
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    check("idle_busy",      32'(busy),      32'(0));
    check("idle_rsp_valid", 32'(rsp_valid), 32'(0));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req_ready"},  32'(req_ready),  32'(0));
    check({tag, "_rsp_valid"},  32'(rsp_valid),  32'(0));
    check({tag, "_busy"},       32'(busy),       32'(0));
    check({tag, "_rsp_result"}, rsp_result,      32'(0));
    check({tag, "_rsp_zl"},     32'({rsp_zero, rsp_less}), 32'(0));
    check({tag, "_alu_a"},      alu_a,           32'(0));
    check({tag, "_alu_op"},     32'({alu_aluop, alu_funct3, alu_funct7, alu_shamt}), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    for (int s = 0; s < 2; s++) begin
      pa[s] = '0; pb[s] = '0; pop[s] = '0; er[s] = '0; ez[s] = 1'b0; el[s] = 1'b0;
    end
    drive_payload();
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;
    exp_last = 1'b1;

    // Single-slot operations
    load(0, 32'd5, 32'd3, mk_op(ALUOP_ARITH, F3_ADD, 7'd0, 5'd0), 32'd8, 1'b0, 1'b0);
    run_one(0, w);
    load(1, 32'd5, 32'd5, mk_op(ALUOP_ARITH, F3_ADD, FUNCT7_ALT, 5'd0), 32'd0, 1'b1, 1'b0);
    run_one(4, w);

    // Dual requests straight after reset
    do_reset();
    load(0, 32'hFFFF_FFFF, 32'd1, mk_op(ALUOP_CMP, F3_SLT, 7'd0, 5'd0), 32'd1, 1'b0, 1'b1);
    load(1, 32'h8000_0000, 32'd0, mk_op(ALUOP_SHIFT, F3_SR, FUNCT7_ALT, 5'd4),
         32'hF800_0000, 1'b0, 1'b1);
    run_one(0, w);
    run_one(0, w);
    load(0, 32'h0000_F0F0, 32'h0000_0FF0, mk_op(ALUOP_ARITH, F3_XOR, 7'd0, 5'd0),
         32'h0000_FF00, 1'b0, 1'b0);
    load(1, 32'h0000_F0F0, 32'h0000_0FF0, mk_op(ALUOP_ARITH, F3_OR, 7'd0, 5'd0),
         32'h0000_FFF0, 1'b0, 1'b0);
    run_one(0, w);
    run_one(1, w);

    // Pass-through of shift, unsigned compare and unsupported ALUOp
    load(0, 32'd1, 32'd0, mk_op(ALUOP_SHIFT, F3_SLL, 7'd0, 5'd31), 32'h8000_0000, 1'b0, 1'b0);
    run_one(0, w);
    load(1, 32'hFFFF_FFFF, 32'd1, mk_op(ALUOP_CMP, F3_SLTU, 7'd0, 5'd0), 32'd0, 1'b1, 1'b1);
    run_one(0, w);
    load(0, 32'd7, 32'd9, mk_op(2'b11, F3_ADD, 7'd0, 5'd0), 32'd0, 1'b1, 1'b1);
    run_one(2, w);

    // Reset while in EXEC: the op is dropped
    load(0, 32'd11, 32'd22, mk_op(ALUOP_ARITH, F3_ADD, 7'd0, 5'd0), 32'd33, 1'b0, 1'b1);
    accept(w);
    void'(sb_q.pop_back());
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_last = 1'b1;
    check_reset_state("rst_exec");
    @(posedge clk); #1;
    check("rst_exec_after_rsp_valid", 32'(rsp_valid), 32'(0));

    // Reset while in RESP with no response accepted
    load(1, 32'd3, 32'd4, mk_op(ALUOP_ARITH, F3_AND, 7'd0, 5'd0), 32'd0, 1'b1, 1'b1);
    accept(w);
    void'(sb_q.pop_back());
    @(posedge clk); #1;
    check("rst_resp_pre_valid", 32'(rsp_valid), 32'(2'b10));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_last = 1'b1;
    check_reset_state("rst_resp");

    // Continuous dual requests: grants alternate starting with slot 0
    load_model(0);
    load_model(1);
    for (int k = 0; k < 6; k++) begin
      run_one(0, w);
      load_model(w);
    end
    run_one(0, w);
    run_one(0, w);

    repeat (2) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
